// File: rtl/fwd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_if
//   Bundle between the ID/EX pipeline control and the forwarding/hazard
//   controller.
//   Handshake contract: there is no valid/ready pair. id_valid qualifies the
//   ID fields in the cycle they are presented. When stall is high, the
//   producer must hold PC and IF/ID, so the same ID fields are presented
//   again next cycle. flush discards the ID instruction in the same cycle.
//   master : pipeline side (drives ID fields and flush, reads selects/stall)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic              stall;
  logic              ex_mem_read;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_reg_write,
           id_mem_read, flush,
    input  fwd_a_sel, fwd_b_sel, stall, ex_mem_read
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dest, id_reg_write,
           id_mem_read, flush,
    output fwd_a_sel, fwd_b_sel, stall, ex_mem_read
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Control for the EX-stage operand forwarding muxes of a 5-stage pipeline.
//   Tracks destination tags of the instructions in EX, MEM and WB, produces
//   the operand A/B mux selects (00 regfile, 01 EX/MEM, 10 MEM/WB), and
//   raises a one-cycle load-use stall. A branch flush drops the ID
//   instruction and beats the stall.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : ID fields, flush, fwd_a_sel, fwd_b_sel, stall,
//                  ex_mem_read (observe: EX holds a valid load)
// Optional (macro FWD_STATS_EN):
//   stall_count  : saturating count of stall cycles
//   fwd_count    : saturating count of cycles with any non-zero select
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_hazard_ctrl_if.slave   bus
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]        stall_count,
  output logic [15:0]        fwd_count
`endif
);

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);

  // EX stage shadow
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q, ex_rt_d;
  logic              ex_uses_rt_q, ex_uses_rt_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  // MEM / WB only need what decides "writer"
  logic              mem_valid_q, mem_reg_write_q;
  logic [REG_AW-1:0] mem_dest_q;
  logic              wb_valid_q, wb_reg_write_q;
  logic [REG_AW-1:0] wb_dest_q;

  logic              mem_writer, wb_writer, stall_w;
  logic [SEL_W-1:0]  sel_a, sel_b;

  assign mem_writer = mem_valid_q & mem_reg_write_q & (mem_dest_q != '0);
  assign wb_writer  = wb_valid_q  & wb_reg_write_q  & (wb_dest_q  != '0);

  // Load in EX whose result the ID instruction needs: there is no path
  // from MEM data back into EX in the same cycle, so hold ID one cycle.
  assign stall_w = bus.id_valid & ex_valid_q & ex_mem_read_q &
                   (ex_dest_q != '0) &
                   ((ex_dest_q == bus.id_rs) |
                    (bus.id_uses_rt & (ex_dest_q == bus.id_rt))) &
                   ~bus.flush;

  // Selects come from registered state only; MEM checked first so the
  // youngest producer wins.
  always_comb begin
    sel_a = SEL_RF;
    sel_b = SEL_RF;
    if (ex_valid_q) begin
      if (mem_writer && (mem_dest_q == ex_rs_q))      sel_a = SEL_MEM;
      else if (wb_writer && (wb_dest_q == ex_rs_q))   sel_a = SEL_WB;
      if (ex_uses_rt_q) begin
        if (mem_writer && (mem_dest_q == ex_rt_q))    sel_b = SEL_MEM;
        else if (wb_writer && (wb_dest_q == ex_rt_q)) sel_b = SEL_WB;
      end
    end
  end

  // EX next state: ID fields, or a bubble on stall/flush. Tags of a bubble
  // are don't-care because every use is gated by valid.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_rs_d        = ex_rs_q;
    ex_rt_d        = ex_rt_q;
    ex_uses_rt_d   = ex_uses_rt_q;
    ex_dest_d      = ex_dest_q;
    if (!stall_w && !bus.flush) begin
      ex_valid_d     = bus.id_valid;
      ex_reg_write_d = bus.id_reg_write;
      ex_mem_read_d  = bus.id_mem_read;
      ex_rs_d        = bus.id_rs;
      ex_rt_d        = bus.id_rt;
      ex_uses_rt_d   = bus.id_uses_rt;
      ex_dest_d      = bus.id_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_uses_rt_q    <= 1'b0;
      ex_dest_q       <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_dest_q      <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_dest_q       <= '0;
    end else begin
      wb_valid_q      <= mem_valid_q;
      wb_reg_write_q  <= mem_reg_write_q;
      wb_dest_q       <= mem_dest_q;
      mem_valid_q     <= ex_valid_q;
      mem_reg_write_q <= ex_reg_write_q;
      mem_dest_q      <= ex_dest_q;
      ex_valid_q      <= ex_valid_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_uses_rt_q    <= ex_uses_rt_d;
      ex_dest_q       <= ex_dest_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
    end
  end

  assign bus.fwd_a_sel   = sel_a;
  assign bus.fwd_b_sel   = sel_b;
  assign bus.stall       = stall_w;
  assign bus.ex_mem_read = ex_valid_q & ex_mem_read_q;

`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      fwd_cnt_q   <= 16'd0;
    end else begin
      if (stall_w && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (((sel_a != SEL_RF) || (sel_b != SEL_RF)) && (fwd_cnt_q != 16'hFFFF))
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign fwd_count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } ins_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  fwd_hazard_ctrl_if #(.REG_AW(5), .SEL_W(2)) bus ();

`ifdef FWD_STATS_EN
  logic [15:0] stall_count;
  logic [15:0] fwd_count;
`endif

  fwd_hazard_ctrl #(.REG_AW(5), .SEL_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FWD_STATS_EN
    ,
    .stall_count (stall_count),
    .fwd_count   (fwd_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] = instruction in EX, hist[1] = MEM, hist[2] = WB
  ins_t hist[$];
  logic [1:0] exp_a, exp_b;
  logic       exp_stall, exp_emr;
  logic [1:0] obs_a, obs_b;
  logic       obs_stall, obs_emr;
  int         exp_stall_cnt, exp_fwd_cnt;

  function automatic ins_t mk(logic v, logic [4:0] rs, logic [4:0] rt,
                              logic ur, logic [4:0] dest, logic rw, logic mr);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.ur = ur; i.dest = dest; i.rw = rw; i.mr = mr;
    return i;
  endfunction

  function automatic ins_t nop();
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  task automatic clear_model();
    hist.delete();
    repeat (3) hist.push_back(nop());
    exp_stall_cnt = 0;
    exp_fwd_cnt   = 0;
  endtask

  // Which older instruction (1 cycle ahead = MEM, 2 cycles = WB) most
  // recently produced register r, if it actually writes a non-zero reg.
  function automatic logic [1:0] ref_sel(logic [4:0] r, logic en);
    if (!en || !hist[0].v) return 2'd0;
    for (int k = 1; k <= 2; k++)
      if (hist[k].v && hist[k].rw && hist[k].dest != 5'd0 && hist[k].dest == r)
        return 2'(k);
    return 2'd0;
  endfunction

  // ---------------- driver ----------------
  // Presents one ID instruction for one cycle, samples the DUT at the
  // falling edge, and advances the model at the rising edge.
  task automatic step(input ins_t id, input logic fl);
    ins_t ex;
    bus.id_valid     = id.v;
    bus.id_rs        = id.rs;
    bus.id_rt        = id.rt;
    bus.id_uses_rt   = id.ur;
    bus.id_dest      = id.dest;
    bus.id_reg_write = id.rw;
    bus.id_mem_read  = id.mr;
    bus.flush        = fl;
    @(negedge clk);
    obs_a     = bus.fwd_a_sel;
    obs_b     = bus.fwd_b_sel;
    obs_stall = bus.stall;
    obs_emr   = bus.ex_mem_read;
    ex        = hist[0];
    exp_a     = ref_sel(ex.rs, 1'b1);
    exp_b     = ref_sel(ex.rt, ex.ur);
    exp_emr   = ex.v & ex.mr;
    exp_stall = id.v && ex.v && ex.mr && ex.dest != 5'd0 &&
                (ex.dest == id.rs || (id.ur && ex.dest == id.rt)) && !fl;
    @(posedge clk);
    if (exp_stall) exp_stall_cnt++;
    if (exp_a != 2'd0 || exp_b != 2'd0) exp_fwd_cnt++;
    hist.push_front((exp_stall || fl) ? nop() : id);
    void'(hist.pop_back());
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(nop(), 1'b0);
    n_tests++;
    if ({obs_a, obs_b, obs_stall, obs_emr} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got a=%b b=%b st=%b emr=%b want all 0",
               obs_a, obs_b, obs_stall, obs_emr);
    end
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_mem_fwd();
    do_reset();
    step(mk(1, 5'd1, 5'd2, 1, 5'd3, 1, 0), 1'b0);  // add $3,$1,$2
    step(mk(1, 5'd3, 5'd5, 1, 5'd4, 1, 0), 1'b0);  // sub $4,$3,$5
    n_tests++;
    if (obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL mem_fwd_no_stall got %b want 0", obs_stall);
    end
    step(nop(), 1'b0);                              // sub now in EX
    n_tests++;
    if (obs_a !== 2'b01 || obs_b !== 2'b00) begin
      n_fail++; $display("FAIL mem_fwd_sel got a=%b b=%b want a=01 b=00", obs_a, obs_b);
    end
  endtask

  task automatic test_wb_fwd();
    do_reset();
    step(mk(1, 5'd1, 5'd2, 1, 5'd3, 1, 0), 1'b0);  // add $3
    step(nop(), 1'b0);
    step(mk(1, 5'd7, 5'd3, 1, 5'd6, 1, 0), 1'b0);  // or $6,$7,$3
    step(nop(), 1'b0);
    n_tests++;
    if (obs_a !== 2'b00 || obs_b !== 2'b10) begin
      n_fail++; $display("FAIL wb_fwd_sel got a=%b b=%b want a=00 b=10", obs_a, obs_b);
    end
  endtask

  task automatic test_load_use();
    ins_t add9;
    do_reset();
    add9 = mk(1, 5'd8, 5'd8, 1, 5'd9, 1, 0);
    step(mk(1, 5'd1, 5'd0, 0, 5'd8, 1, 1), 1'b0);  // lw $8
    step(add9, 1'b0);
    n_tests++;
    if (obs_stall !== 1'b1 || obs_emr !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall got st=%b emr=%b want 1 1", obs_stall, obs_emr);
    end
    step(add9, 1'b0);                               // held in ID
    n_tests++;
    if (obs_stall !== 1'b0 || obs_a !== 2'b00 || obs_b !== 2'b00) begin
      n_fail++; $display("FAIL load_use_bubble got st=%b a=%b b=%b want 0 00 00",
                         obs_stall, obs_a, obs_b);
    end
    step(nop(), 1'b0);                              // add in EX, lw in WB
    n_tests++;
    if (obs_a !== 2'b10 || obs_b !== 2'b10) begin
      n_fail++; $display("FAIL load_use_wb_fwd got a=%b b=%b want 10 10", obs_a, obs_b);
    end
    // load followed by a store that needs the data through rt
    step(mk(1, 5'd1, 5'd0, 0, 5'd4, 1, 1), 1'b0);  // lw $4
    step(mk(1, 5'd2, 5'd4, 1, 5'd0, 0, 0), 1'b0);  // sw $4,0($2)
    n_tests++;
    if (obs_stall !== 1'b1) begin
      n_fail++; $display("FAIL store_data_stall got %b want 1", obs_stall);
    end
  endtask

  task automatic test_zero_and_priority();
    do_reset();
    step(mk(1, 5'd1, 5'd2, 1, 5'd0, 1, 0), 1'b0);  // add $0,$1,$2
    step(mk(1, 5'd0, 5'd0, 1, 5'd5, 1, 0), 1'b0);  // add $5,$0,$0
    step(nop(), 1'b0);
    n_tests++;
    if (obs_a !== 2'b00 || obs_b !== 2'b00) begin
      n_fail++; $display("FAIL zero_reg_sel got a=%b b=%b want 00 00", obs_a, obs_b);
    end
    do_reset();
    step(mk(1, 5'd1, 5'd0, 0, 5'd2, 1, 0), 1'b0);  // addi $2
    step(mk(1, 5'd3, 5'd4, 1, 5'd2, 1, 0), 1'b0);  // add $2
    step(mk(1, 5'd2, 5'd2, 1, 5'd6, 1, 0), 1'b0);  // use $2,$2
    step(nop(), 1'b0);
    n_tests++;
    if (obs_a !== 2'b01 || obs_b !== 2'b01) begin
      n_fail++; $display("FAIL mem_priority_sel got a=%b b=%b want 01 01", obs_a, obs_b);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(mk(1, 5'd1, 5'd0, 0, 5'd8, 1, 1), 1'b0);  // lw $8
    step(mk(1, 5'd8, 5'd8, 1, 5'd9, 1, 0), 1'b1);  // dependent, flushed
    n_tests++;
    if (obs_stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_stall got %b want 0", obs_stall);
    end
    step(nop(), 1'b0);
    n_tests++;
    if (obs_a !== 2'b00 || obs_b !== 2'b00 || obs_emr !== 1'b0) begin
      n_fail++; $display("FAIL flush_bubble got a=%b b=%b emr=%b want 00 00 0",
                         obs_a, obs_b, obs_emr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(mk(1, 5'd1, 5'd2, 1, 5'd3, 1, 0), 1'b0);  // add $3
    step(mk(1, 5'd3, 5'd3, 1, 5'd7, 1, 0), 1'b0);  // use $3 -> now in EX
    #2;
    n_tests++;
    if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b01) begin
      n_fail++; $display("FAIL pre_reset_sel got a=%b b=%b want 01 01",
                         bus.fwd_a_sel, bus.fwd_b_sel);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00 ||
        bus.stall !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got a=%b b=%b st=%b emr=%b want all 0",
                         bus.fwd_a_sel, bus.fwd_b_sel, bus.stall, bus.ex_mem_read);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    step(mk(1, 5'd3, 5'd3, 1, 5'd7, 1, 0), 1'b0);
    n_tests++;
    if (obs_a !== 2'b00 || obs_b !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_sel got a=%b b=%b want 00 00", obs_a, obs_b);
    end
  endtask

  task automatic test_random();
    ins_t cur;
    logic fl;
    do_reset();
    cur = nop();
    for (int c = 0; c < 400; c++) begin
      if (!exp_stall || c == 0) begin
        cur = mk(logic'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 2) == 0));
      end
      fl = ($urandom_range(0, 9) == 0);
      step(cur, fl);
      n_tests++;
      if (obs_a !== exp_a || obs_b !== exp_b || obs_stall !== exp_stall ||
          obs_emr !== exp_emr) begin
        n_fail++;
        $display("FAIL random_cycle%0d got a=%b b=%b st=%b emr=%b want a=%b b=%b st=%b emr=%b",
                 c, obs_a, obs_b, obs_stall, obs_emr, exp_a, exp_b, exp_stall, exp_emr);
      end
    end
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats();
    ins_t use8;
    do_reset();
    use8 = mk(1, 5'd8, 5'd8, 1, 5'd9, 1, 0);
    repeat (3) begin
      step(mk(1, 5'd1, 5'd0, 0, 5'd8, 1, 1), 1'b0);
      step(use8, 1'b0);
      step(use8, 1'b0);
      step(nop(), 1'b0);
    end
    #2;
    n_tests++;
    if (stall_count !== 16'd3) begin
      n_fail++; $display("FAIL stall_count got %0d want 3", stall_count);
    end
    n_tests++;
    if (fwd_count !== 16'(exp_fwd_cnt)) begin
      n_fail++; $display("FAIL fwd_count got %0d want %0d", fwd_count, exp_fwd_cnt);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    clear_model();
    exp_stall = 1'b0;
    test_reset();
    test_mem_fwd();
    test_wb_fwd();
    test_load_use();
    test_zero_and_priority();
    test_flush();
    test_async_reset();
    test_random();
`ifdef FWD_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control side of the EX-stage operand forwarding muxes (4:1, 32-bit, sel 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result) in the 5-stage pipeline.
- Keeps a shadow pipeline of destination-register tags for EX, MEM and WB.
- Drives the two mux selects for the instruction in EX.
- Detects load-use hazards and stalls IF/ID for one cycle. Accepts a branch flush.

Parameters:
- REG_AW, 5, register address width.
- SEL_W, 2, forwarding select width; fixed encoding 00/01/10; 11 is never driven.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  instruction in ID is real (not a bubble).
- id_rs  input  REG_AW  ID source register A.
- id_rt  input  REG_AW  ID source register B.
- id_uses_rt  input  1  ID instruction reads rt as an operand (R-type, beq, sw).
- id_dest  input  REG_AW  ID destination register, after the RegDst choice.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch taken; discard the instruction in ID.
- fwd_a_sel  output  SEL_W  select for the EX operand A mux.
- fwd_b_sel  output  SEL_W  select for the EX operand B mux.
- stall  output  1  hold PC and IF/ID; EX receives a bubble.
- ex_mem_read  output  1  EX stage holds a valid load (debug/observe).

Behaviour:
- Reset (rst_n low, asynchronous): all shadow stages are cleared. Every valid, reg_write, mem_read and tag register goes to 0.
  - Outputs during and after reset: fwd_a_sel=00, fwd_b_sel=00, stall=0, ex_mem_read=0.
  - Reset mid-operation drops all in-flight tags. There is no forwarding in the first cycle after release.
- Shadow pipeline, every rising edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields (valid, rs, rt, uses_rt, dest, reg_write, mem_read) when stall=0 and flush=0.
  - Otherwise EX <= bubble (valid=0, reg_write=0, mem_read=0).
- "Writer" condition for a stage X: X_valid & X_reg_write & (X_dest != 0). Register $0 is never forwarded.
- fwd_a_sel is combinational from registered state only. It has zero-cycle latency relative to the EX contents:
  - 01 if MEM is a writer and mem_dest == ex_rs.
  - else 10 if WB is a writer and wb_dest == ex_rs.
  - else 00.
  - MEM has priority over WB when both match (most recent value wins).
- fwd_b_sel: same rule applied to ex_rt, and only when ex_uses_rt=1; otherwise 00.
- Both selects are 00 whenever ex_valid=0.
- stall is combinational:
  - stall = id_valid & ex_valid & ex_mem_read & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)) & ~flush.
  - Asserted for exactly one cycle per load-use pair. The next cycle the load is in MEM, so the condition clears and the consumer later receives 10 from WB.
- flush has priority over stall: stall=0 and EX receives a bubble. Instructions already in MEM and WB are unaffected.
- A load followed by a dependent store-data use (id_uses_rt=1, rt match) also stalls. There is no MEM-to-MEM forwarding.
- Back-to-back writers of the same register: the younger (MEM) result is selected.

Optional Feature:
- Macro: FWD_STATS_EN.
- Defined:
  - Adds output stall_count (16 bit), reset to 0.
  - Increments on each cycle with stall=1.
  - Saturates at 16'hFFFF with no wrap.
  - Adds output fwd_count (16 bit), same rules, incremented when either select is non-zero.
- Undefined: neither port exists, and the core behaviour is identical.

Test Plan:
- add $3,$1,$2 then sub $4,$3,$5 back-to-back -> when sub is in EX, fwd_a_sel=01 and fwd_b_sel=00; stall never asserts.
- add $3,... ; nop ; or $6,$7,$3 -> when or is in EX, fwd_b_sel=10 and fwd_a_sel=00.
- lw $8,0($1) then add $9,$8,$8 -> stall=1 for exactly one cycle with EX bubble. Next cycle stall=0; when add is in EX, fwd_a_sel=fwd_b_sel=10.
- add $0,$1,$2 then add $5,$0,$0 -> both selects remain 00. Also addi $2 followed by add $2 followed by use $2 -> sel=01 (MEM wins over WB).
- lw $8 in EX with dependent ID and flush=1 the same cycle -> stall=0; EX bubble next cycle, so selects are 00 for that slot.
- rst_n pulsed low mid-stream with a writer in MEM -> selects go to 00 immediately (asynchronous). With FWD_STATS_EN, 3 load-use stalls produce stall_count=3.
